// File: rtl/pwm_dac_out_if.sv
// Sample/control bundle between a waveform generator and the PWM DAC stage.
// The generator (master) supplies samples and gain; the DAC (slave) returns
// the one-cycle request used to advance the generator once per PWM period.
interface pwm_dac_out_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AMP_W  = 5
);
  logic              en;
  logic [DATA_W-1:0] sample_in;
  logic [AMP_W-1:0]  amplitude;
  logic              sample_req;

  modport master (output en, output sample_in, output amplitude, input sample_req);
  modport slave  (input en, input sample_in, input amplitude, output sample_req);
endinterface

// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: scales a signed sample by amplitude/16, converts it
// to offset-binary and drives a single PWM pin with period 2^DATA_W clocks.
// The duty value only changes at period boundaries, so the pin never glitches.
module pwm_dac_out #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AMP_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_dac_out_if.slave      bus,
  output logic              pwm_out,
  output logic [DATA_W-1:0] duty
);

  localparam int unsigned       PW        = DATA_W + AMP_W + 1;
  localparam logic [DATA_W-1:0] CNT_LAST  = '1;
  localparam logic [DATA_W-1:0] CNT_CAP   = CNT_LAST - DATA_W'(1);
  // Request is registered, so it is launched one count early to be high
  // exactly during the cycle cnt == CNT_LAST-2.
  localparam logic [DATA_W-1:0] CNT_REQ_D = CNT_LAST - DATA_W'(3);
  localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [AMP_W-1:0]  AMP_FULL  = AMP_W'(16);

  typedef enum logic {HOLD, RUN} phase_t;

  phase_t              phase;
  logic [DATA_W-1:0]   cnt;
  logic [DATA_W-1:0]   s_q;
  logic [AMP_W-1:0]    a_q;
  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] prod;
  logic [DATA_W-1:0]   scaled;

  // Run/hold phase follows the enable directly.
  always_comb begin
    phase = bus.en ? RUN : HOLD;
  end

  // Period counter, sample request and PWM pin; all quiet while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      bus.sample_req <= 1'b0;
      pwm_out        <= 1'b0;
    end else if (phase == RUN) begin
      cnt            <= cnt + DATA_W'(1);
      bus.sample_req <= (cnt == CNT_REQ_D);
      pwm_out        <= (cnt < duty);
    end else begin
      bus.sample_req <= 1'b0;
      pwm_out        <= 1'b0;
    end
  end

  // Capture sample and saturated gain once per period, one cycle before the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      a_q <= '0;
    end else if (phase == RUN && cnt == CNT_CAP) begin
      s_q <= bus.sample_in;
      a_q <= (bus.amplitude > AMP_FULL) ? AMP_FULL : bus.amplitude;
    end
  end

  // Signed scale by a_q/16 with floor rounding; gain <= 1 so no overflow.
  always_comb begin
    s_ext  = {{(PW-DATA_W){s_q[DATA_W-1]}}, s_q};
    a_ext  = {{(PW-AMP_W){1'b0}}, a_q};
    prod   = s_ext * a_ext;
    scaled = DATA_W'(prod >>> 4);
  end

  // Load the new offset-binary duty at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= MIDSCALE;
    end else if (phase == RUN && cnt == CNT_LAST) begin
      duty <= {~scaled[DATA_W-1], scaled[DATA_W-2:0]};
    end
  end

endmodule

// File: tb/tb_pwm_dac_out.sv
// Directed bench for pwm_dac_out: per-period duty/high-time/request checks,
// sine-generator chaining, enable hold behaviour and asynchronous reset.
module tb_pwm_dac_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pwm_out;
  logic [7:0] duty;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned tcnt = 0;   // bench model of the period counter
  logic [2:0]  idx;        // bench sine generator phase

  logic [7:0] sine_lut [8] = '{8'h00, 8'h5A, 8'h7F, 8'h5A, 8'h00, 8'hA6, 8'h81, 8'hA6};
  logic [7:0] sine_duty[8] = '{8'h80, 8'hDA, 8'hFF, 8'hDA, 8'h80, 8'h26, 8'h01, 8'h26};

  // vector: sample, amplitude, toggle-others flag, expected duty next period
  logic [7:0] v_s  [12] = '{8'h00, 8'h7F, 8'h81, 8'h5A, 8'hA6, 8'hFF, 8'h01, 8'h5A, 8'h5A, 8'h80, 8'h7F, 8'h33};
  logic [4:0] v_a  [12] = '{5'd16, 5'd16, 5'd16, 5'd8,  5'd8,  5'd1,  5'd1,  5'd0,  5'd31, 5'd16, 5'd15, 5'd16};
  logic       v_t  [12] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
  logic [7:0] v_e  [12] = '{8'h80, 8'hFF, 8'h01, 8'hAD, 8'h53, 8'h7F, 8'h80, 8'h80, 8'hDA, 8'h00, 8'hF7, 8'hB3};

  pwm_dac_out_if #(.DATA_W(8), .AMP_W(5)) dif ();

  pwm_dac_out #(.DATA_W(8), .AMP_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (dif),
    .pwm_out (pwm_out),
    .duty    (duty)
  );

  always #5 clk = ~clk;

  // Upstream generator advanced by sample_req used as clock enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx <= 3'd0;
    else if (dif.sample_req) idx <= idx + 3'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the model counter follows the enable seen at the edge.
  task automatic cyc();
    @(posedge clk);
    if (dif.en) tcnt = (tcnt + 1) % 256;
    @(negedge clk);
  endtask

  task automatic run_to(input int unsigned c);
    for (int unsigned g = 0; g < 600 && tcnt != c; g++) cyc();
  endtask

  // Runs one full period from tcnt==0, driving stimulus and checking results.
  task automatic measure(input logic [7:0] s, input logic [4:0] a, input logic tog,
                         input logic gen, input logic [7:0] exp_d, input string tag);
    int unsigned hi = 0;
    int unsigned nreq = 0;
    int unsigned reqpos = 999;
    logic [7:0]  d_end = 8'h00;
    check({tag, "_duty_start"}, 32'(duty), 32'(exp_d));
    for (int i = 0; i < 256; i++) begin
      if (pwm_out) hi++;
      if (dif.sample_req) begin
        nreq++;
        reqpos = tcnt;
      end
      if (i == 255) d_end = duty;
      if (gen) begin
        dif.sample_in = sine_lut[idx];
        dif.amplitude = a;
      end else if (tog && tcnt != 254) begin
        dif.sample_in = tcnt[0] ? 8'h7F : 8'h81;
        dif.amplitude = tcnt[0] ? 5'd0 : 5'd31;
      end else begin
        dif.sample_in = s;
        dif.amplitude = a;
      end
      cyc();
    end
    check({tag, "_duty_end"}, 32'(d_end), 32'(exp_d));
    check({tag, "_high"}, hi, 32'(exp_d));
    check({tag, "_nreq"}, nreq, 1);
    check({tag, "_reqpos"}, reqpos, 253);
  endtask

  initial begin
    logic [7:0]  prev;
    int unsigned i0;
    int unsigned n;
    int unsigned bad;

    dif.en = 1'b0;
    dif.sample_in = 8'h00;
    dif.amplitude = 5'd16;

    #2 rst_n = 1'b0;
    #1;
    check("rst_duty", 32'(duty), 32'h80);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_req", 32'(dif.sample_req), 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dif.en = 1'b1;
    tcnt = 0;

    prev = 8'h80;
    for (int k = 0; k < 12; k++) begin
      measure(v_s[k], v_a[k], v_t[k], 1'b0, prev, $sformatf("vec%0d", k));
      prev = v_e[k];
    end

    i0 = 32'(idx);
    for (int j = 0; j < 9; j++) begin
      measure(8'h00, 5'd16, 1'b0, 1'b1,
              (j == 0) ? prev : sine_duty[(i0 + j) % 8], $sformatf("sine%0d", j));
    end
    prev = sine_duty[(i0 + 9) % 8];

    // Enable dropped during the capture cycle: capture waits for re-enable.
    dif.sample_in = 8'h81;
    dif.amplitude = 5'd16;
    run_to(254);
    dif.en = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    dif.sample_in = 8'h7F;
    dif.en = 1'b1;
    cyc();
    check("skip_cap_duty_held", 32'(duty), 32'(prev));
    cyc();
    measure(8'h7F, 5'd16, 1'b0, 1'b0, 8'hFF, "after_skip");

    // Hold at cnt==100 for 50 clocks, then time the next request.
    run_to(100);
    dif.en = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (pwm_out !== 1'b0 || dif.sample_req !== 1'b0) bad++;
    end
    check("hold_quiet", bad, 0);
    check("hold_duty", 32'(duty), 32'hFF);
    dif.en = 1'b1;
    n = 0;
    for (int g = 0; g < 400; g++) begin
      cyc();
      n++;
      if (dif.sample_req) break;
    end
    check("resume_req_delay", n, 153);
    check("pre_reset_pwm", 32'(pwm_out), 1);

    // Asynchronous reset mid-period, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_duty", 32'(duty), 32'h80);
    check("async_rst_pwm", 32'(pwm_out), 0);
    check("async_rst_req", 32'(dif.sample_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tcnt = 0;
    measure(8'h00, 5'd16, 1'b0, 1'b0, 8'h80, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_dac_out.md
Name: pwm_dac_out

Overview:
- Output stage directly downstream of the 8-bit signed waveform generators (sine LUT and siblings).
- Scales each signed sample by a 0..16/16 amplitude and converts it to offset-binary.
- Drives a single-bit PWM pin for an external RC low-pass DAC.
- Issues a one-cycle sample request so the upstream generator can advance exactly once per PWM period.

Parameters:
- DATA_W, 8, sample width; PWM counter width equals DATA_W (period 2^DATA_W clocks).
- AMP_W, 5, amplitude control width; codes 0..16 valid.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable
- sample_in  input  DATA_W  signed two's-complement sample from generator
- amplitude  input  AMP_W  gain numerator; gain = amplitude/16; codes >16 saturate to 16
- sample_req  output  1  one-cycle pulse requesting next sample (usable as generator clock enable)
- pwm_out  output  1  registered PWM output
- duty  output  DATA_W  currently active duty value, offset-binary (debug/observe)

Behaviour:
- Reset (async, rst_n=0): cnt=0, duty=0x80 (midscale, i.e. zero signal), s_q=0, a_q=0, sample_req=0, pwm_out=0. Asserting reset mid-period clears everything immediately. First period after release uses duty 0x80.
- Period counter cnt: DATA_W bits; increments by 1 each clock while en=1; wraps 255->0; holds while en=0.
- sample_req: registered; high for exactly the cycle in which cnt==253 (with en=1); otherwise 0.
  - One pulse per 256 enabled clocks.
  - Upstream updating on the edge ending cnt==253 presents the new sample during cnt==254.
- Capture: on the edge ending a cycle with cnt==254 and en=1, s_q<=sample_in and a_q<=min(amplitude,16). sample_in and amplitude at any other time are ignored.
- Scale: prod = s_q * a_q, signed, DATA_W+AMP_W+1 bits. scaled = prod >>> 4 (arithmetic shift, floor toward -inf), truncated to DATA_W.
  - No overflow is possible since the gain is <= 1.
  - a_q=16 returns s_q exactly.
  - a_q=0 returns 0.
- Load: on the edge ending cnt==255 with en=1, duty <= scaled with MSB inverted (i.e. scaled+128). The new duty is active from cnt==0 of the next period.
  - Latency: sample_req pulse to new duty active = 3 clocks.
  - Sample capture to duty active = 2 clocks.
- PWM: each enabled clock, pwm_out <= (cnt < duty), unsigned compare. High-time per period is exactly duty clocks, delayed 1 clock relative to cnt.
  - duty=0: always low.
  - duty=255: high 255 of 256 clocks. 100% duty is not reachable, by design.
- en=0: cnt, duty, s_q, a_q hold; sample_req=0; pwm_out<=0 on the next edge.
  - On en re-assertion, counting resumes from the held cnt with no new request until cnt reaches 253.
  - If en drops in the cycle cnt==254 or 255, that capture/load is skipped and occurs when cnt next reaches that value enabled.
- No FSM beyond the counter phases: RUN (en=1) / HOLD (en=0). Duty changes only at period boundaries, so PWM never glitches mid-period.

Test Plan:
- Reset then release, en=1, sample_in=0x00, amplitude=16 -> duty=0x80 for periods 0 and 1; pwm_out high 128 of 256 clocks; sample_req pulses at cnt 253, 509, ...
- sample_in=0x7F, amplitude=16 -> duty=0xFF next period, pwm_out high 255/256; sample_in=0x81 -> duty=0x01, pwm high 1/256.
- amplitude=8, sample_in=0x5A -> duty=0xAD (45+128); sample_in=0xA6 (-90), amplitude=8 -> -45 floor -> duty=0x53; amplitude=0 -> 0x80; amplitude=31 -> same as 16.
- Connect sample_req as clock enable of the 8-slice sine generator -> duty sequence 0x80,0xDA,0xFF,0xDA,0x80,0x26,0x01,0x26 repeating, one value per 256 clocks.
- Toggle sample_in every cycle except cnt==254 -> duty reflects only the value held during cnt==254.
- Drop en at cnt==100 for 50 clocks -> cnt frozen at 100, pwm_out=0, no sample_req; on resume, pulse occurs 153 enabled clocks later; assert rst_n=0 mid-period -> all outputs to reset values without a clock edge.
